// File: rtl/freelist_pkg.sv
// ----------------------------------------------------------------------------
// freelist_pkg
//   Shared constants for the physical-register free list.
//   WIDTH_REG : physical tag width (pool holds 2**WIDTH_REG tags)
//   NUM_ARCH  : architectural registers mapped at reset (tags 0..NUM_ARCH-1)
//   LANES     : commit / allocate bundle width
//   TAG_NONE  : tag 0, the hardwired-zero / "no destination" tag
//   FL_LANE   : macro selecting lane k of a packed *4x bus
// Optional feature macro used by the other files: FREELIST_CHECK_EN.
// ----------------------------------------------------------------------------
`ifndef FREELIST_PKG_SV
`define FREELIST_PKG_SV

// Lane k of a packed multi-lane bus; lane 0 sits in the least-significant bits.
`define FL_LANE(bus, k, w) bus[(k)*(w) +: (w)]

package freelist_pkg;
    localparam int WIDTH_REG = 7;
    localparam int NUM_ARCH  = 32;
    localparam int LANES     = 4;
    localparam int TAG_NONE  = 0;
endpackage

`endif

// File: rtl/freelist_if.sv
// ----------------------------------------------------------------------------
// freelist_if
//   Groups the commit-side release bundle and the rename-side allocate
//   bundle of the free list.
//   i_com_prd4x   : four committed tags, lane k at [k*W +: W]
//   i_com_en      : commit bundle valid (all four lanes presented)
//   i_alloc_req   : rename takes four tags this cycle
//   o_alloc_prd4x : next four free tags, same lane packing
//   o_alloc_valid : at least four tags free
//   o_free_cnt    : number of free tags
//   o_err         : sticky misuse flag (only with FREELIST_CHECK_EN)
//
// Handshake: an allocation transfers on a rising edge where i_alloc_req and
// o_alloc_valid are both high; o_alloc_valid plays the "valid" role and
// i_alloc_req the "ready" role. o_alloc_prd4x is stable while o_alloc_valid
// is high and no transfer occurs. i_com_en has no back-pressure: a commit
// bundle is always accepted on the edge where it is presented.
// ----------------------------------------------------------------------------
interface freelist_if
    import freelist_pkg::*;
#(
    parameter int W = WIDTH_REG
);
    logic [LANES*W-1:0] i_com_prd4x;
    logic               i_com_en;
    logic               i_alloc_req;
    logic [LANES*W-1:0] o_alloc_prd4x;
    logic               o_alloc_valid;
    logic [W:0]         o_free_cnt;
`ifdef FREELIST_CHECK_EN
    logic               o_err;

    modport master (
        output i_com_prd4x, i_com_en, i_alloc_req,
        input  o_alloc_prd4x, o_alloc_valid, o_free_cnt, o_err
    );
    modport slave (
        input  i_com_prd4x, i_com_en, i_alloc_req,
        output o_alloc_prd4x, o_alloc_valid, o_free_cnt, o_err
    );
`else
    modport master (
        output i_com_prd4x, i_com_en, i_alloc_req,
        input  o_alloc_prd4x, o_alloc_valid, o_free_cnt
    );
    modport slave (
        input  i_com_prd4x, i_com_en, i_alloc_req,
        output o_alloc_prd4x, o_alloc_valid, o_free_cnt
    );
`endif
endinterface

// File: rtl/freelist_compact.sv
// ----------------------------------------------------------------------------
// freelist_compact
//   Combinational 4-lane zero-skip compactor. Lanes carrying TAG_NONE are
//   dropped; the remaining tags are packed toward lane 0 keeping ascending
//   lane order.
//   tags_i : raw committed tags, lane k at [k*W +: W]
//   comp_o : compacted tags; lanes at index >= n_o are zero
//   n_o    : number of nonzero input lanes (0..4)
// ----------------------------------------------------------------------------
module freelist_compact
    import freelist_pkg::*;
#(
    parameter int W = WIDTH_REG
) (
    input  logic [LANES*W-1:0] tags_i,
    output logic [LANES*W-1:0] comp_o,
    output logic [2:0]         n_o
);
    always_comb begin
        int cnt;
        comp_o = '0;
        cnt    = 0;
        for (int k = 0; k < LANES; k++) begin
            if (`FL_LANE(tags_i, k, W) != W'(TAG_NONE)) begin
                comp_o[cnt*W +: W] = `FL_LANE(tags_i, k, W);
                cnt = cnt + 1;
            end
        end
        n_o = 3'(cnt);
    end
endmodule

// File: rtl/freelist.sv
// ----------------------------------------------------------------------------
// freelist
//   Physical-register free list. A ring buffer of free tags: rename pops four
//   tags at head (all-or-nothing), commit pushes up to four nonzero tags at
//   tail after zero-skip compaction. Tags released in a cycle become visible
//   on the allocate port from the next cycle.
//   i_clk : clock, all state changes on the rising edge
//   i_rst : synchronous active-high reset (wins over same-cycle traffic)
//   bus   : freelist_if slave modport (commit bundle, allocate bundle, count)
// Optional feature macro: FREELIST_CHECK_EN adds a free bitmap and a sticky
// o_err flag for double frees, duplicate lanes and release overflow.
// ----------------------------------------------------------------------------
module freelist
    import freelist_pkg::*;
(
    input  logic      i_clk,
    input  logic      i_rst,
    freelist_if.slave bus
);
    localparam int W     = WIDTH_REG;
    localparam int DEPTH = 1 << W;

    logic [W-1:0]       mem_q [DEPTH];
    logic [W-1:0]       head_q, head_d;
    logic [W-1:0]       tail_q, tail_d;
    logic [W:0]         count_q, count_d;

    logic [LANES*W-1:0] comp;
    logic [2:0]         rel_n;
    logic [W+1:0]       room;
    logic [2:0]         wr_n;
    logic               alloc_valid;
    logic               alloc_fire;

    freelist_compact #(.W(W)) u_compact (
        .tags_i (bus.i_com_prd4x),
        .comp_o (comp),
        .n_o    (rel_n)
    );

    assign alloc_valid = (count_q >= (W+1)'(LANES));
    assign alloc_fire  = bus.i_alloc_req && alloc_valid;

    // Free slots before this cycle's allocation; a release larger than this
    // is truncated to the first 'room' compacted lanes.
    assign room = (W+2)'(DEPTH) - {1'b0, count_q};

    always_comb begin
        wr_n = '0;
        if (bus.i_com_en) begin
            wr_n = ((W+2)'(rel_n) > room) ? room[2:0] : rel_n;
        end
    end

    always_comb begin
        head_d  = head_q + (alloc_fire ? W'(LANES) : W'(0));
        tail_d  = tail_q + W'(wr_n);
        count_d = count_q - (alloc_fire ? (W+1)'(LANES) : (W+1)'(0))
                          + (W+1)'(wr_n);
    end

    always_comb begin
        bus.o_alloc_prd4x = '0;
        for (int k = 0; k < LANES; k++) begin
            `FL_LANE(bus.o_alloc_prd4x, k, W) = mem_q[head_q + W'(k)];
        end
    end

    assign bus.o_alloc_valid = alloc_valid;
    assign bus.o_free_cnt    = count_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= (i < DEPTH - NUM_ARCH) ? W'(NUM_ARCH + i) : W'(0);
            end
            head_q  <= '0;
            tail_q  <= W'(DEPTH - NUM_ARCH);
            count_q <= (W+1)'(DEPTH - NUM_ARCH);
        end else begin
            for (int k = 0; k < LANES; k++) begin
                if (k < int'(wr_n)) begin
                    mem_q[tail_q + W'(k)] <= comp[k*W +: W];
                end
            end
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

`ifdef FREELIST_CHECK_EN
    // One bit per tag, set while the tag sits in the pool.
    logic [DEPTH-1:0] map_q, map_d;
    logic             err_q, err_d;

    always_comb begin
        map_d = map_q;
        err_d = err_q;
        if (alloc_fire) begin
            for (int k = 0; k < LANES; k++) begin
                map_d[`FL_LANE(bus.o_alloc_prd4x, k, W)] = 1'b0;
            end
        end
        // Checks look at the pre-cycle bitmap, so a tag freed twice in one
        // bundle is caught by the pairwise compare rather than the bitmap.
        for (int k = 0; k < LANES; k++) begin
            if (bus.i_com_en && (k < int'(rel_n))) begin
                if (map_q[comp[k*W +: W]]) begin
                    err_d = 1'b1;
                end
                for (int j = 0; j < k; j++) begin
                    if (comp[j*W +: W] == comp[k*W +: W]) begin
                        err_d = 1'b1;
                    end
                end
                if (k < int'(wr_n)) begin
                    map_d[comp[k*W +: W]] = 1'b1;
                end
            end
        end
        if (bus.i_com_en && ((W+2)'(rel_n) > room)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                map_q[i] <= (i >= NUM_ARCH);
            end
            err_q <= 1'b0;
        end else begin
            map_q <= map_d;
            err_q <= err_d;
        end
    end

    assign bus.o_err = err_q;
`endif
endmodule

// File: tb/tb_freelist.sv
// ----------------------------------------------------------------------------
// tb_freelist
//   Bench for freelist: table of vectors after reset, hand sequences for the
//   drain / same-cycle / overflow corners, then randomized traffic checked
//   against a queue-based model of the free pool.
// ----------------------------------------------------------------------------
module tb_freelist;
    import freelist_pkg::*;

    localparam int W     = WIDTH_REG;
    localparam int DEPTH = 1 << W;

    logic i_clk = 1'b0;
    logic i_rst = 1'b1;
    always #5 i_clk = ~i_clk;

    freelist_if bus ();

    freelist dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus)
    );

    // Model: fl_q is the pool in FIFO order; used_q holds tags currently
    // owned by the core (legal to release).
    int fl_q[$];
    int used_q[$];
    int pass_cnt  = 0;
    int total_cnt = 0;

    typedef struct {
        bit alloc;
        bit en;
        int t3, t2, t1, t0;
        int exp_cnt;
        bit exp_valid;
        int exp_lane0;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic int lane_out(input int k);
        return int'(bus.o_alloc_prd4x[k*W +: W]);
    endfunction

    task automatic drive(input bit alloc, input bit en,
                         input int t3, input int t2, input int t1, input int t0);
        bus.i_alloc_req = alloc;
        bus.i_com_en    = en;
        bus.i_com_prd4x = {W'(t3), W'(t2), W'(t1), W'(t0)};
    endtask

    task automatic model_reset();
        fl_q.delete();
        used_q.delete();
        for (int i = NUM_ARCH; i < DEPTH; i++) fl_q.push_back(i);
        for (int i = 1; i < NUM_ARCH; i++) used_q.push_back(i);
    endtask

    task automatic model_step();
        int room;
        int tags[4];
        if (i_rst) begin
            model_reset();
            return;
        end
        room = DEPTH - fl_q.size();
        for (int k = 0; k < LANES; k++) tags[k] = int'(bus.i_com_prd4x[k*W +: W]);
        if (bus.i_alloc_req && fl_q.size() >= LANES) begin
            for (int k = 0; k < LANES; k++) used_q.push_back(fl_q.pop_front());
        end
        if (bus.i_com_en) begin
            for (int k = 0; k < LANES; k++) begin
                if (tags[k] != 0 && room > 0) begin
                    fl_q.push_back(tags[k]);
                    room--;
                end
            end
        end
    endtask

    task automatic model_check();
        chk("free_cnt", int'(bus.o_free_cnt), fl_q.size());
        chk("alloc_valid", int'(bus.o_alloc_valid), (fl_q.size() >= LANES) ? 1 : 0);
        if (fl_q.size() >= LANES) begin
            for (int k = 0; k < LANES; k++)
                chk($sformatf("alloc_lane%0d", k), lane_out(k), fl_q[k]);
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge i_clk);
        #1;
        model_check();
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        tick();
        i_rst = 1'b0;
    endtask

    initial begin
        bit en;
        int t[4];
        int idx;

        vecs[0] = '{1, 0, 0, 0, 0, 0, 92, 1, 36};
        vecs[1] = '{0, 1, 0, 0, 0, 0, 92, 1, 36};
        vecs[2] = '{1, 1, 3, 0, 2, 1, 91, 1, 40};
        vecs[3] = '{0, 0, 9, 9, 9, 9, 91, 1, 40};
        vecs[4] = '{1, 0, 0, 0, 0, 0, 87, 1, 44};

        drive(0, 0, 0, 0, 0, 0);

        // Reset state.
        do_reset();
        chk("rst_cnt", int'(bus.o_free_cnt), 96);
        chk("rst_valid", int'(bus.o_alloc_valid), 1);
        chk("rst_lane0", lane_out(0), 32);
        chk("rst_lane3", lane_out(3), 35);
`ifdef FREELIST_CHECK_EN
        chk("rst_err", int'(bus.o_err), 0);
`endif

        // Table vectors.
        for (int v = 0; v < 5; v++) begin
            drive(vecs[v].alloc, vecs[v].en, vecs[v].t3, vecs[v].t2, vecs[v].t1, vecs[v].t0);
            tick();
            chk($sformatf("vec%0d_cnt", v), int'(bus.o_free_cnt), vecs[v].exp_cnt);
            chk($sformatf("vec%0d_valid", v), int'(bus.o_alloc_valid), int'(vecs[v].exp_valid));
            chk($sformatf("vec%0d_lane0", v), lane_out(0), vecs[v].exp_lane0);
        end

        // Drain the pool, then stall.
        do_reset();
        for (int i = 0; i < 24; i++) begin
            drive(1, 0, 0, 0, 0, 0);
            tick();
        end
        chk("drain_cnt", int'(bus.o_free_cnt), 0);
        chk("drain_valid", int'(bus.o_alloc_valid), 0);
        for (int i = 0; i < 2; i++) begin
            drive(1, 0, 0, 0, 0, 0);
            tick();
        end
        chk("stall_cnt", int'(bus.o_free_cnt), 0);

        // Compacting release into the drained pool.
        drive(0, 1, 7, 0, 5, 0);
        tick();
        chk("rel1_cnt", int'(bus.o_free_cnt), 2);
        chk("rel1_valid", int'(bus.o_alloc_valid), 0);
        drive(0, 1, 0, 10, 9, 0);
        tick();
        chk("rel2_cnt", int'(bus.o_free_cnt), 4);
        chk("rel2_lane0", lane_out(0), 5);
        chk("rel2_lane1", lane_out(1), 7);
        chk("rel2_lane2", lane_out(2), 9);
        chk("rel2_lane3", lane_out(3), 10);

        // Same-cycle allocate and release at count 8.
        drive(0, 1, 14, 13, 12, 11);
        tick();
        chk("same_pre_cnt", int'(bus.o_free_cnt), 8);
        drive(1, 1, 40, 41, 42, 43);
        tick();
        chk("same_cnt", int'(bus.o_free_cnt), 8);
        chk("same_lane0", lane_out(0), 11);
        chk("same_lane3", lane_out(3), 14);
        drive(1, 0, 0, 0, 0, 0);
        tick();
        chk("same_post_cnt", int'(bus.o_free_cnt), 4);
        chk("same_post_lane0", lane_out(0), 43);
        chk("same_post_lane3", lane_out(3), 40);
`ifdef FREELIST_CHECK_EN
        chk("same_err", int'(bus.o_err), 0);
`endif

        // Fill to the top, then overflow.
        do_reset();
        for (int i = 0; i < 7; i++) begin
            drive(0, 1, 4*i+4, 4*i+3, 4*i+2, 4*i+1);
            tick();
        end
        drive(0, 1, 0, 31, 30, 29);
        tick();
        chk("full_cnt", int'(bus.o_free_cnt), 127);
`ifdef FREELIST_CHECK_EN
        chk("full_err", int'(bus.o_err), 0);
`endif
        drive(0, 1, 8, 7, 6, 5);
        tick();
        chk("ovf_cnt", int'(bus.o_free_cnt), 128);
        drive(0, 1, 8, 7, 6, 5);
        tick();
        chk("ovf2_cnt", int'(bus.o_free_cnt), 128);
`ifdef FREELIST_CHECK_EN
        chk("ovf_err", int'(bus.o_err), 1);
`endif

`ifdef FREELIST_CHECK_EN
        // Double free of tag 50 after it has been allocated once.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1, 0, 0, 0, 0, 0);
            tick();
        end
        drive(0, 1, 0, 0, 0, 50);
        tick();
        chk("df1_err", int'(bus.o_err), 0);
        drive(0, 1, 0, 0, 0, 50);
        tick();
        chk("df2_err", int'(bus.o_err), 1);
        drive(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) tick();
        chk("df_sticky", int'(bus.o_err), 1);
        do_reset();
        chk("df_rst", int'(bus.o_err), 0);
`endif

        // Randomized traffic across many pointer wraps.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            en = ($urandom_range(0, 1) == 1);
            for (int k = 0; k < LANES; k++) begin
                if (en && used_q.size() > 0 && $urandom_range(0, 3) != 0) begin
                    idx = $urandom_range(0, used_q.size() - 1);
                    t[k] = used_q[idx];
                    used_q.delete(idx);
                end else if (en) begin
                    t[k] = 0;
                end else begin
                    t[k] = $urandom_range(0, DEPTH - 1);
                end
            end
            drive($urandom_range(0, 99) < 55, en, t[3], t[2], t[1], t[0]);
            tick();
        end
`ifdef FREELIST_CHECK_EN
        chk("rand_err", int'(bus.o_err), 0);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/freelist.md
Name: freelist

Overview:
- Physical-register free list at the commit end of the ROB interface.
- Consumes the ROB commit bundle (committed destination tags and a commit enable) and returns those tags to a circular pool.
- Supplies four free physical tags per cycle to rename/dispatch, which feeds the ROB dispatch port.
- Ring-buffer storage with 4-wide compacting release and 4-wide all-or-nothing allocate.

Parameters:
- WIDTH_REG, 7, physical tag width; pool capacity DEPTH = 2**WIDTH_REG entries.
- NUM_ARCH, 32, architectural registers mapped at reset; tags 0..NUM_ARCH-1 are not free at reset.

Ports:
- i_clk  in  1  clock; all state changes on rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_com_prd4x  in  4*WIDTH_REG  committed tags; lane k at bits [k*WIDTH_REG +: WIDTH_REG].
- i_com_en  in  1  commit bundle valid; all four lanes presented.
- i_alloc_req  in  1  rename takes four tags this cycle.
- o_alloc_prd4x  out  4*WIDTH_REG  next four free tags, same lane packing.
- o_alloc_valid  out  1  at least four tags free.
- o_free_cnt  out  WIDTH_REG+1  number of free tags.

Behaviour:
- Reset (i_rst high at an edge):
  - entry[i] = NUM_ARCH+i for i = 0..DEPTH-NUM_ARCH-1; other entries 0.
  - head = 0, tail = DEPTH-NUM_ARCH, count = DEPTH-NUM_ARCH (96 with defaults).
  - Reset overrides any same-cycle commit or alloc.
- Outputs, combinational from registered state:
  - o_alloc_prd4x lane k = entry[(head+k) mod DEPTH].
  - o_alloc_valid = (count >= 4).
  - o_free_cnt = count.
  - After reset: o_alloc_prd4x = {35,34,33,32}, o_alloc_valid = 1, o_free_cnt = 96.
- Allocate:
  - Fires when i_alloc_req && o_alloc_valid: head += 4 (mod DEPTH).
  - i_alloc_req with o_alloc_valid low is ignored; no partial allocation; rename must stall.
- Release:
  - Fires when i_com_en. Lanes with tag 0 are skipped (p0 is the hardwired zero / no-destination tag).
  - Remaining lanes are compacted in ascending lane order and written to entry[tail], entry[tail+1], ... (mod DEPTH).
  - n = number of nonzero lanes (0..4); tail += n.
- Count update: count_next = count - 4*alloc_fire + n.
  - Released tags are not visible on o_alloc_prd4x until the next cycle, even if head reaches them.
- Wrap-around: head and tail are WIDTH_REG-bit and wrap naturally; lane addressing wraps mod DEPTH.
- Full: count never exceeds DEPTH-1 in correct operation, because p0 is never released.
  - A release that would exceed DEPTH is truncated: only the first DEPTH-count compacted lanes are written.
- Empty / low: count < 4 holds o_alloc_valid low; release still proceeds normally.
- Same-cycle allocate and release: both apply. Head and tail are independent pointers, so there is no storage conflict.
- Latency: one cycle from commit to tag availability; zero-cycle combinational tag presentation.

Optional Feature:
- Macro: FREELIST_CHECK_EN.
- With the macro:
  - Adds a DEPTH-bit free bitmap, reset to 1 for tags NUM_ARCH..DEPTH-1.
  - Alloc clears bits; release sets bits.
  - Adds port o_err (1 bit), registered and sticky until reset. It is set when a released nonzero tag already has its bit set (double free), two lanes in one bundle carry the same nonzero tag, or a release overflow truncates.
- Without the macro: no bitmap and no o_err port; overflow truncation as above; double frees go undetected.

Decomposition:
- Shared package:
  - WIDTH_REG default.
  - NUM_ARCH.
  - LANES = 4.
  - Tag-0 "no destination" constant.
  - Lane-packing helper macro for *4x buses.
- Sub-module freelist_compact: combinational 4-lane zero-skip compactor producing compacted tags and count n. All pointer/storage state stays in freelist.

Test Plan:
- Reset then idle -> o_alloc_prd4x={35,34,33,32}, o_alloc_valid=1, o_free_cnt=96.
- Allocate 24 consecutive cycles, no commits -> o_free_cnt 0, o_alloc_valid 0; further i_alloc_req leaves head unchanged.
- Commit i_com_prd4x={7,0,5,0}, i_com_en=1 in a drained state -> next cycle o_free_cnt=2; entries at tail are 5 then 7.
- Same-cycle alloc and commit {40,41,42,43} at count=8 -> next cycle count=8; committed tags appear only after head wraps to them.
- Drive head/tail across index 127->0 with repeated alloc/commit -> tags delivered in FIFO order across the wrap, none lost or duplicated.
- With FREELIST_CHECK_EN: commit tag 50 twice without an intervening alloc of it -> o_err rises one cycle after the second commit and stays high until i_rst.
